ifetch_unit: RTL and testbench

- Instruction-fetch initiator that drives the word-addressed program/exception ROM (16-bit addr, chip select, 32-bit combinational read data) from an internal PC.
- Presents fetched words to decode through a valid/ready output register.
- Handles branch redirects, exception entry into the 0x80xx exception region, and exception return.
- Sits between the ROM and the decode stage of the MIPS core.

---
 rtl/ifetch_unit.sv | 107 ++++++++++
 tb/tb_ifetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: walks a word-addressed ROM from an internal PC and
// hands fetched words to decode through a valid/ready output register.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] EXC_BASE = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        br_valid,
  input  logic [15:0] br_target,
  input  logic        exc_req,
  input  logic [7:0]  exc_vec,
  input  logic [15:0] exc_pc,
  input  logic        eret,
  output logic [15:0] epc,
  output logic        in_exc
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]  state;
  logic        pc_region;
  logic [7:0]  pc_index;
  logic        load;
  logic        redirect;
  logic        target_region;
  logic [7:0]  target_index;
  logic        unused_bits;

  // Only the region bit and the 8-bit index are architecturally meaningful.
  assign unused_bits = ^{br_target[14:8], epc[14:8], EXC_BASE[14:8]};

  assign rom_addr = {pc_region, 7'b0, pc_index};
  assign load     = !out_valid || out_ready;
  assign rom_cs   = (state == FETCH) && load;
  assign redirect = exc_req || eret || br_valid;

  always_comb begin
    target_region = br_target[15];
    target_index  = br_target[7:0];
    if (exc_req) begin
      target_region = EXC_BASE[15];
      target_index  = EXC_BASE[7:0] | exc_vec;
    end else if (eret) begin
      target_region = epc[15];
      target_index  = epc[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc_region <= RESET_PC[15];
      pc_index  <= RESET_PC[7:0];
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      epc       <= '0;
      in_exc    <= 1'b0;
    end else if (redirect) begin
      // Redirect overrides any fetch this cycle; BOOT is kept so its exit still takes a cycle.
      pc_region <= target_region;
      pc_index  <= target_index;
      out_valid <= 1'b0;
      if (state != BOOT) state <= FETCH;
      if (exc_req) begin
        if (!in_exc) begin
          epc    <= exc_pc;
          in_exc <= 1'b1;
        end
      end else if (eret) begin
        in_exc <= 1'b0;
      end
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (load) begin
            out_instr <= rom_data;
            out_pc    <= rom_addr;
            out_valid <= 1'b1;
            pc_index  <= pc_index + 8'd1;
          end else begin
            state <= STALL;
          end
        end
        STALL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run scored against
// a stream-level model (expected next PC, epc, in_exc).
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        br_valid = 1'b0;
  logic [15:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic [7:0]  exc_vec = '0;
  logic [15:0] exc_pc = '0;
  logic        eret = 1'b0;
  logic [15:0] epc;
  logic        in_exc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] romword(input logic [8:0] idx);
    case (idx)
      9'd0: return 32'h11;
      9'd1: return 32'h22;
      9'd2: return 32'h33;
      9'd3: return 32'h44;
      default: return {7'h2B, idx, 16'hC0DE};
    endcase
  endfunction

  function automatic logic [8:0] rom_idx(input logic [15:0] a);
    return {a[15], a[7:0]};
  endfunction

  assign rom_data = rom_cs ? romword(rom_idx(rom_addr)) : 32'hDEAD_BEEF;

  ifetch_unit #(.RESET_PC(16'h0000), .EXC_BASE(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .br_valid(br_valid), .br_target(br_target), .exc_req(exc_req), .exc_vec(exc_vec),
    .exc_pc(exc_pc), .eret(eret), .epc(epc), .in_exc(in_exc)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    br_valid = 1'b0; br_target = '0; exc_req = 1'b0; exc_vec = '0; exc_pc = '0; eret = 1'b0;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0; out_ready = 1'b0; clear_inputs();
    cyc(); cyc();
    rst_n = 1'b1; out_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clear_inputs();
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h want=0", out_valid); end
    total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL rst_cs got=%h want=0", rom_cs); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", out_instr); end
    total++; if (out_pc !== 16'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", out_pc); end
    total++; if (epc !== 16'h0 || in_exc !== 1'b0) begin bad++; $display("FAIL rst_epc got=%h/%h want=0/0", epc, in_exc); end
    cyc(); cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (rom_cs !== 1'b0) begin bad++; $display("FAIL boot_cs got=%h want=0", rom_cs); end
    cyc();
    total++; if (out_valid !== 1'b0 || rom_cs !== 1'b1 || rom_addr !== 16'h0) begin
      bad++; $display("FAIL first_fetch got v=%h cs=%h a=%h want v=0 cs=1 a=0000", out_valid, rom_cs, rom_addr); end
    cyc();
    for (int unsigned i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_instr !== romword(9'(i))) begin
        bad++; $display("FAIL stream%0d got v=%h pc=%h i=%h want v=1 pc=%h i=%h", i, out_valid, out_pc, out_instr, 16'(i), romword(9'(i))); end
      cyc();
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    cyc(); cyc();
    for (int unsigned k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h11 || out_pc !== 16'h0 || rom_cs !== 1'b0) begin
        bad++; $display("FAIL hold%0d got v=%h i=%h pc=%h cs=%h want v=1 i=11 pc=0 cs=0", k, out_valid, out_instr, out_pc, rom_cs); end
      if (k < 2) cyc();
    end
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b0 || rom_cs !== 1'b1 || rom_addr !== 16'h1) begin
      bad++; $display("FAIL release got v=%h cs=%h a=%h want v=0 cs=1 a=0001", out_valid, rom_cs, rom_addr); end
    cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 16'h1 || out_instr !== 32'h22) begin
      bad++; $display("FAIL after_stall1 got v=%h pc=%h i=%h want v=1 pc=0001 i=22", out_valid, out_pc, out_instr); end
    cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 16'h2 || out_instr !== 32'h33) begin
      bad++; $display("FAIL after_stall2 got v=%h pc=%h i=%h want v=1 pc=0002 i=33", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    cyc(); cyc();
    br_valid = 1'b1; br_target = 16'h3AFF;
    cyc();
    br_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || rom_addr !== 16'h00FF || rom_cs !== 1'b1) begin
      bad++; $display("FAIL br_flush got v=%h a=%h cs=%h want v=0 a=00ff cs=1", out_valid, rom_addr, rom_cs); end
    cyc();
    total++; if (out_pc !== 16'h00FF || out_instr !== romword(9'h0FF)) begin
      bad++; $display("FAIL wrap_lo_a got pc=%h i=%h want pc=00ff i=%h", out_pc, out_instr, romword(9'h0FF)); end
    cyc();
    total++; if (out_pc !== 16'h0000 || out_instr !== 32'h11) begin
      bad++; $display("FAIL wrap_lo_b got pc=%h i=%h want pc=0000 i=11", out_pc, out_instr); end
    exc_req = 1'b1; exc_vec = 8'hFF; exc_pc = 16'h0001;
    cyc();
    exc_req = 1'b0;
    total++; if (rom_addr !== 16'h80FF) begin bad++; $display("FAIL exc_addr got=%h want=80ff", rom_addr); end
    cyc();
    total++; if (out_pc !== 16'h80FF || out_instr !== romword(9'h1FF)) begin
      bad++; $display("FAIL wrap_hi_a got pc=%h i=%h want pc=80ff i=%h", out_pc, out_instr, romword(9'h1FF)); end
    cyc();
    total++; if (out_pc !== 16'h8000 || out_instr !== romword(9'h100)) begin
      bad++; $display("FAIL wrap_hi_b got pc=%h i=%h want pc=8000 i=%h", out_pc, out_instr, romword(9'h100)); end
  endtask

  task automatic test_exc_nesting();
    do_reset(1'b0);
    cyc(); cyc(); cyc();
    exc_req = 1'b1; exc_vec = 8'h10; exc_pc = 16'h0005;
    cyc();
    exc_req = 1'b0;
    total++; if (out_valid !== 1'b0 || epc !== 16'h0005 || in_exc !== 1'b1) begin
      bad++; $display("FAIL exc_stall got v=%h epc=%h ie=%h want v=0 epc=0005 ie=1", out_valid, epc, in_exc); end
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 16'h8010 || out_instr !== romword(9'h110)) begin
      bad++; $display("FAIL exc_first got v=%h pc=%h i=%h want v=1 pc=8010 i=%h", out_valid, out_pc, out_instr, romword(9'h110)); end
    exc_req = 1'b1; exc_vec = 8'h20; exc_pc = 16'h0077;
    cyc();
    exc_req = 1'b0;
    total++; if (epc !== 16'h0005 || in_exc !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL exc_nested got epc=%h ie=%h v=%h want epc=0005 ie=1 v=0", epc, in_exc, out_valid); end
    cyc();
    total++; if (out_pc !== 16'h8020) begin bad++; $display("FAIL exc_nested_pc got=%h want=8020", out_pc); end
  endtask

  task automatic test_eret();
    do_reset(1'b1);
    cyc();
    exc_req = 1'b1; exc_vec = 8'h10; exc_pc = 16'h0005;
    cyc();
    exc_req = 1'b0;
    cyc();
    eret = 1'b1; br_valid = 1'b1; br_target = 16'h0040;
    cyc();
    eret = 1'b0; br_valid = 1'b0;
    total++; if (in_exc !== 1'b0 || epc !== 16'h0005 || rom_addr !== 16'h0005) begin
      bad++; $display("FAIL eret_pri got ie=%h epc=%h a=%h want ie=0 epc=0005 a=0005", in_exc, epc, rom_addr); end
    cyc();
    total++; if (out_pc !== 16'h0005 || out_instr !== romword(9'h005)) begin
      bad++; $display("FAIL eret_word got pc=%h i=%h want pc=0005 i=%h", out_pc, out_instr, romword(9'h005)); end
    exc_req = 1'b1; exc_vec = 8'h30; exc_pc = 16'h0009; eret = 1'b1;
    cyc();
    clear_inputs();
    total++; if (in_exc !== 1'b1 || epc !== 16'h0009) begin
      bad++; $display("FAIL exc_over_eret got ie=%h epc=%h want ie=1 epc=0009", in_exc, epc); end
    cyc();
    total++; if (out_pc !== 16'h8030) begin bad++; $display("FAIL exc_over_eret_pc got=%h want=8030", out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    cyc();
    exc_req = 1'b1; exc_vec = 8'h44; exc_pc = 16'h0033;
    cyc();
    exc_req = 1'b0;
    cyc();
    br_valid = 1'b1; br_target = 16'h0080;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_instr !== 32'h0) begin
      bad++; $display("FAIL midrst_out got v=%h pc=%h i=%h want 0/0000/0", out_valid, out_pc, out_instr); end
    total++; if (epc !== 16'h0 || in_exc !== 1'b0 || rom_cs !== 1'b0 || rom_addr !== 16'h0) begin
      bad++; $display("FAIL midrst_st got epc=%h ie=%h cs=%h a=%h want 0000/0/0/0000", epc, in_exc, rom_cs, rom_addr); end
    clear_inputs();
    cyc(); cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    cyc(); cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 16'h0 || out_instr !== 32'h11) begin
      bad++; $display("FAIL midrst_restart got v=%h pc=%h i=%h want v=1 pc=0000 i=11", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_random();
    logic [15:0] m_exp;
    logic [15:0] m_epc;
    logic        m_in;
    logic        must_hold;
    logic        redir;
    int          streak;
    do_reset(1'b0);
    m_exp = 16'h0000; m_epc = 16'h0000; m_in = 1'b0; must_hold = 1'b0; streak = 0;
    repeat (3000) begin
      out_ready = ($urandom_range(3) != 0);
      exc_req   = ($urandom_range(39) == 0);
      eret      = ($urandom_range(29) == 0);
      br_valid  = ($urandom_range(14) == 0);
      exc_vec   = 8'($urandom);
      exc_pc    = 16'($urandom);
      br_target = 16'($urandom);
      #1;
      redir = exc_req || eret || br_valid;
      total++; if (epc !== m_epc || in_exc !== m_in) begin
        bad++; $display("FAIL rnd_exc got epc=%h ie=%h want epc=%h ie=%h", epc, in_exc, m_epc, m_in); end
      if (must_hold) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rnd_hold got v=%h want v=1", out_valid); end
      end
      if (rom_cs) begin
        total++; if (rom_addr[14:8] !== 7'h0 || (out_valid && !out_ready)) begin
          bad++; $display("FAIL rnd_cs got a=%h v=%h r=%h want mid=0 and no fetch while blocked", rom_addr, out_valid, out_ready); end
      end
      if (out_valid) begin
        total++; if (out_pc !== m_exp || out_instr !== romword(rom_idx(m_exp))) begin
          bad++; $display("FAIL rnd_word got pc=%h i=%h want pc=%h i=%h", out_pc, out_instr, m_exp, romword(rom_idx(m_exp))); end
      end
      if (out_valid || redir) streak = 0;
      else begin
        streak++;
        total++; if (streak > 2) begin bad++; $display("FAIL rnd_live got idle=%0d want <=2", streak); end
      end
      must_hold = out_valid && !out_ready && !redir;
      if (exc_req) begin
        if (!m_in) begin m_epc = exc_pc; m_in = 1'b1; end
        m_exp = 16'h8000 | {8'h00, exc_vec};
      end else if (eret) begin
        m_exp = {m_epc[15], 7'b0, m_epc[7:0]};
        m_in = 1'b0;
      end else if (br_valid) begin
        m_exp = {br_target[15], 7'b0, br_target[7:0]};
      end else if (out_valid && out_ready) begin
        m_exp = {m_exp[15], 7'b0, m_exp[7:0] + 8'd1};
      end
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_wrap();
    test_exc_nesting();
    test_eret();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
